lvl_sample_replay_ctrl: RTL and testbench

Sequencer in front of sample2lvl_converter. It captures one frame of level-crossing samples (dir bit + 15-bit timestamp) from the SGDMA stream into an internal buffer. It then replays the frame to the converter ITER times, issuing a synchronous reset pulse to the converter before each pass so that every pass starts from the converter's reset level. This supports iterative reconstruction without re-fetching the frame over DMA.

---
 rtl/lvl_sample_replay_ctrl.sv | 163 ++++++++++++++++
 tb/tb_lvl_sample_replay_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvl_sample_replay_ctrl.sv
// Captures one frame of level-crossing samples from the DMA stream, then replays it
// to the converter a configurable number of times, resetting the converter before each pass.
module lvl_sample_replay_ctrl #(
  parameter int MAX_SAMPLES     = 255,
  parameter int ITER_W          = 4,
  parameter int CONV_RST_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        cfg_num_samples,
  input  logic [ITER_W-1:0] cfg_iter_num,
  input  logic [15:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [15:0]       conv_data,
  output logic              conv_valid,
  input  logic              conv_ready,
  output logic              conv_reset,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_idx
);

  localparam int PTR_W = $clog2(MAX_SAMPLES + 1);
  localparam int CNT_W = $clog2(CONV_RST_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLR,
    ST_PLAY,
    ST_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [PTR_W-1:0]  num_reg;
  logic [ITER_W-1:0] iter_num_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [ITER_W-1:0] iter_idx_reg;
  logic [CNT_W-1:0]  clr_cnt_reg;
  logic [CNT_W-1:0]  abort_cnt_reg;

  logic [15:0] mem [MAX_SAMPLES];
  logic [15:0] rd_data_reg;
  logic [PTR_W-1:0] rd_addr;
  logic        rd_en;

  logic cfg_ok, start_ok, abort_hit;
  logic in_fire, wr_en, conv_fire;
  logic last_wr, last_rd, last_iter, clr_last;

  assign cfg_ok    = (cfg_num_samples != 8'd0) && (int'(cfg_num_samples) <= MAX_SAMPLES) &&
                     (cfg_iter_num != '0);
  assign start_ok  = (state_reg == ST_IDLE) && start && cfg_ok;
  assign abort_hit = abort && (state_reg != ST_IDLE);
  assign in_fire   = (state_reg == ST_LOAD) && in_valid;
  assign wr_en     = in_fire && !abort;
  assign conv_fire = (state_reg == ST_PLAY) && conv_ready;
  assign last_wr   = (wr_ptr_reg == num_reg - PTR_W'(1));
  assign last_rd   = (rd_ptr_reg == num_reg - PTR_W'(1));
  assign last_iter = (iter_idx_reg == iter_num_reg - ITER_W'(1));
  assign clr_last  = (clr_cnt_reg == CNT_W'(CONV_RST_CYCLES - 1));

  // Read address runs one step ahead on a handshake so the registered read keeps pace.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    if (state_reg == ST_CLR) begin
      rd_en = 1'b1;
    end else if (state_reg == ST_PLAY) begin
      rd_en   = 1'b1;
      rd_addr = (conv_fire && !last_rd) ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= in_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start_ok) state_next = ST_LOAD;
      ST_LOAD: if (in_fire && last_wr) state_next = ST_CLR;
      ST_CLR:  if (clr_last) state_next = ST_PLAY;
      ST_PLAY: if (conv_fire && last_rd) state_next = last_iter ? ST_DONE : ST_CLR;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (abort_hit) begin
      state_next = ST_IDLE;
    end
  end

  always_comb begin
    in_ready   = (state_reg == ST_LOAD);
    conv_valid = (state_reg == ST_PLAY);
    conv_data  = (state_reg == ST_PLAY) ? rd_data_reg : 16'h0000;
    conv_reset = (state_reg == ST_CLR) || (abort_cnt_reg != '0);
    busy       = (state_reg != ST_IDLE);
    done       = (state_reg == ST_DONE);
    iter_idx   = iter_idx_reg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      num_reg       <= '0;
      iter_num_reg  <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      iter_idx_reg  <= '0;
      clr_cnt_reg   <= '0;
      abort_cnt_reg <= '0;
    end else begin
      if (start_ok) begin
        num_reg      <= PTR_W'(cfg_num_samples);
        iter_num_reg <= cfg_iter_num;
        wr_ptr_reg   <= '0;
        iter_idx_reg <= '0;
      end

      if (wr_en && !last_wr) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end

      clr_cnt_reg <= (state_reg == ST_CLR && !clr_last) ? clr_cnt_reg + CNT_W'(1) : '0;
      rd_ptr_reg  <= (state_reg == ST_PLAY) ? rd_addr : '0;

      if (abort_hit) begin
        iter_idx_reg <= '0;
      end else if (conv_fire && last_rd && !last_iter) begin
        iter_idx_reg <= iter_idx_reg + ITER_W'(1);
      end else if (state_reg == ST_DONE) begin
        iter_idx_reg <= '0;
      end

      // Aborting leaves the converter mid-frame, so give it its own reset pulse.
      if (abort_hit) begin
        abort_cnt_reg <= CNT_W'(CONV_RST_CYCLES);
      end else if (abort_cnt_reg != '0) begin
        abort_cnt_reg <= abort_cnt_reg - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lvl_sample_replay_ctrl.sv
// Bench for lvl_sample_replay_ctrl: frames of random samples are loaded and replayed,
// and each observed word/handshake is compared with the frame the bench itself generated.
module tb_lvl_sample_replay_ctrl;

  localparam int MAX_SAMPLES     = 255;
  localparam int ITER_W          = 4;
  localparam int CONV_RST_CYCLES = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [7:0]        cfg_num_samples;
  logic [ITER_W-1:0] cfg_iter_num;
  logic [15:0]       in_data;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       conv_data;
  logic              conv_valid;
  logic              conv_ready;
  logic              conv_reset;
  logic              busy;
  logic              done;
  logic [ITER_W-1:0] iter_idx;

  int tests = 0;
  int fails = 0;
  logic [15:0] smp[$];

  lvl_sample_replay_ctrl #(
    .MAX_SAMPLES    (MAX_SAMPLES),
    .ITER_W         (ITER_W),
    .CONV_RST_CYCLES(CONV_RST_CYCLES)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .cfg_num_samples(cfg_num_samples),
    .cfg_iter_num   (cfg_iter_num),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .conv_data      (conv_data),
    .conv_valid     (conv_valid),
    .conv_ready     (conv_ready),
    .conv_reset     (conv_reset),
    .busy           (busy),
    .done           (done),
    .iter_idx       (iter_idx)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag, input int cycles);
    tests++;
    fails++;
    $error("FAIL %s observed=%0d_cycles expected=handshake_before_timeout", tag, cycles);
  endtask

  function automatic logic gate(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 3) == 0;
      2:       return (c % 5) == 4;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic fill_random(input int n);
    smp.delete();
    for (int i = 0; i < n; i++) smp.push_back(16'($urandom));
  endtask

  task automatic check_idle_outputs(input string tag, input logic exp_conv_reset);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_conv_valid"}, conv_valid, 1'b0);
    chk({tag, "_conv_data"}, conv_data, 16'h0000);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_iter_idx"}, iter_idx, '0);
    chk({tag, "_conv_reset"}, conv_reset, exp_conv_reset);
  endtask

  // After an abort the converter reset pulse must last exactly CONV_RST_CYCLES, with no done.
  task automatic check_abort_pulse();
    int rc = 0;
    check_idle_outputs("abort", 1'b1);
    while (conv_reset && rc < 10) begin
      chk("abort_done", done, 1'b0);
      rc++;
      step();
    end
    chk("abort_rst_cycles", rc, CONV_RST_CYCLES);
    chk("abort_busy_after", busy, 1'b0);
  endtask

  // stop_kind: 0 none, 1 abort in load, 2 abort in play, 3 system reset in load.
  task automatic run_frame(input int n, input int iters, input int vmode, input int rmode,
                           input int stop_kind, input int stop_pass, input int stop_k);
    int acc = 0;
    int k;
    int rc;
    int budget;
    int c = 0;
    logic hs;
    cfg_num_samples = 8'(n);
    cfg_iter_num    = ITER_W'(iters);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("load_busy", busy, 1'b1);
    chk("load_in_ready", in_ready, 1'b1);
    chk("load_iter_idx", iter_idx, '0);

    budget = 0;
    while (acc < n) begin
      if ((stop_kind == 1 || stop_kind == 3) && acc == stop_k) begin
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        if (stop_kind == 1) abort = 1'b1;
        else reset = 1'b1;
        step();
        abort = 1'b0; reset = 1'b0; in_valid = 1'b0; start = 1'b0;
        if (stop_kind == 1) check_abort_pulse();
        else check_idle_outputs("sysreset", 1'b0);
        return;
      end
      in_valid = gate(vmode, c);
      c++;
      in_data = smp[acc];
      start = 1'($urandom_range(0, 1));
      cfg_num_samples = 8'($urandom);
      cfg_iter_num    = ITER_W'($urandom);
      hs = in_ready && in_valid;
      step();
      if (hs) acc++;
      chk("load_ready_track", in_ready, acc < n);
      budget++;
      if (budget > 5000) begin
        timeout("load_timeout", budget);
        return;
      end
    end
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    start    = 1'b0;

    for (int p = 0; p < iters; p++) begin
      rc = 0;
      budget = 0;
      while (!conv_valid) begin
        chk("clr_in_ready", in_ready, 1'b0);
        chk("clr_done", done, 1'b0);
        if (conv_reset) rc++;
        step();
        budget++;
        if (budget > 20) begin
          timeout("clr_timeout", budget);
          in_valid = 1'b0;
          return;
        end
      end
      in_valid = 1'b0;
      chk("clr_cycles", rc, CONV_RST_CYCLES);
      chk("pass_iter_idx", iter_idx, ITER_W'(p));
      chk("play_conv_reset", conv_reset, 1'b0);

      k = 0;
      budget = 0;
      while (k < n) begin
        chk("play_valid", conv_valid, 1'b1);
        chk("play_data", conv_data, smp[k]);
        conv_ready = gate(rmode, c);
        c++;
        start = 1'($urandom_range(0, 1));
        cfg_num_samples = 8'($urandom);
        if (stop_kind == 2 && p == stop_pass && k == stop_k) begin
          abort = 1'b1;
          conv_ready = 1'b1;
          step();
          abort = 1'b0; conv_ready = 1'b0; start = 1'b0;
          check_abort_pulse();
          return;
        end
        hs = conv_valid && conv_ready;
        step();
        if (hs) k++;
        budget++;
        if (budget > 5000) begin
          timeout("play_timeout", budget);
          conv_ready = 1'b0; start = 1'b0;
          return;
        end
      end
      conv_ready = 1'b0;
      start = 1'b0;
      chk("pass_end_valid", conv_valid, 1'b0);
    end
    chk("done_pulse", done, 1'b1);
    chk("done_busy", busy, 1'b1);
    step();
    chk("done_low", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
  endtask

  task automatic bad_start(input int n, input int iters);
    cfg_num_samples = 8'(n);
    cfg_iter_num    = ITER_W'(iters);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("badcfg_busy", busy, 1'b0);
      chk("badcfg_in_ready", in_ready, 1'b0);
      chk("badcfg_done", done, 1'b0);
      step();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_num_samples = '0; cfg_iter_num = '0;
    in_data = '0; in_valid = 1'b0; conv_ready = 1'b0;
    repeat (3) step();
    check_idle_outputs("reset", 1'b0);
    reset = 1'b0;
    step();

    // Directed frame with known words, continuous valid and ready
    smp.delete();
    smp.push_back(16'h8005);
    smp.push_back(16'h0005);
    smp.push_back(16'h8190);
    run_frame(3, 1, 0, 0, 0, 0, 0);

    // Three passes with a slow converter
    fill_random(4);
    run_frame(4, 3, 0, 2, 0, 0, 0);

    // Sparse source, trailing 0xFFFF offered after the frame
    fill_random(5);
    run_frame(5, 1, 1, 0, 0, 0, 0);

    // Abort in the first of two passes after two handshakes, then a normal frame
    fill_random(6);
    run_frame(6, 2, 0, 0, 2, 0, 2);
    fill_random(2);
    run_frame(2, 1, 0, 0, 0, 0, 0);

    // Abort during load, then single-sample frame
    fill_random(7);
    run_frame(7, 1, 0, 0, 1, 0, 3);
    fill_random(1);
    run_frame(1, 2, 3, 3, 0, 0, 0);

    bad_start(0, 2);
    bad_start(5, 0);

    // System reset mid-load, then a full-depth frame
    fill_random(10);
    run_frame(10, 1, 0, 0, 3, 0, 2);
    step();
    fill_random(MAX_SAMPLES);
    run_frame(MAX_SAMPLES, 1, 0, 0, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(1, 12);
      int it = $urandom_range(1, 3);
      fill_random(n);
      run_frame(n, it, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
